// File: rtl/irq_ctrl.sv
// irq_ctrl -- edge-triggered interrupt controller with fixed priority.
//
// Each source is edge-detected against its previous-cycle value. A rising
// edge latches a pending bit, and the pending bits are gated by mask. The
// lowest-indexed eligible source is presented to the CPU as irq/irq_id. A claim
// pops that source and returns its ID one cycle later. If a source rises again
// while it is still pending, its sticky overflow flag is set.
//
// Parameters:
//   N    number of interrupt sources (2..15)
//   IDW  width of ID fields; ID value 2^IDW-1 (all ones) means "none"
// Ports:
//   clk          clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   src[N]       interrupt sources, rising-edge sensitive
//   mask[N]      per-source enable (1 = enabled), used combinationally
//   claim        single-cycle claim request
//   ovf_clr      clear all overflow flags
//   irq          any eligible (pending & enabled) source
//   irq_id[IDW]  ID of highest-priority eligible source, or NONE
//   claim_valid  one-cycle acknowledge following a claim
//   claim_id     ID returned by the last claim (NONE if nothing was eligible)
//   pending[N]   pending register
//   ovf[N]       sticky overflow flags
module irq_ctrl #(
  parameter int N   = 8,
  parameter int IDW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   src,
  input  logic [N-1:0]   mask,
  input  logic           claim,
  input  logic           ovf_clr,
  output logic           irq,
  output logic [IDW-1:0] irq_id,
  output logic           claim_valid,
  output logic [IDW-1:0] claim_id,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   ovf
);

  localparam logic [IDW-1:0] NONE = '1;

  logic [N-1:0]   r_src_d;
  logic [N-1:0]   r_pending;
  logic [N-1:0]   r_ovf;
  logic           r_claim_valid;
  logic [IDW-1:0] r_claim_id;

  logic [N-1:0]   w_rise;
  logic [N-1:0]   w_eligible;
  logic           w_irq;
  logic [IDW-1:0] w_irq_id;
  logic           w_claim_hit;
  logic [N-1:0]   w_claim_oh;
  logic [N-1:0]   w_ovf_set;
  logic [N-1:0]   w_pending_next;
  logic [N-1:0]   w_ovf_next;

  assign w_rise     = src & ~r_src_d;
  assign w_eligible = r_pending & mask;
  assign w_irq      = |w_eligible;

  // Scan from the top down so the lowest eligible index is the last one written.
  always_comb begin
    w_irq_id = NONE;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_irq_id = IDW'(i);
      end
    end
  end

  // One-hot of the source being claimed this cycle. It is all zeros when
  // nothing is eligible.
  assign w_claim_hit = claim & w_irq;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_claim
      assign w_claim_oh[gi] = w_claim_hit && (w_irq_id == IDW'(gi));
    end
  endgenerate

  // A rise wins over a claim of the same bit. That case is a fresh event and
  // not a lost one, so it does not count as an overflow.
  assign w_pending_next = (r_pending & ~w_claim_oh) | w_rise;
  assign w_ovf_set      = w_rise & r_pending & ~w_claim_oh;
  assign w_ovf_next     = (ovf_clr ? '0 : r_ovf) | w_ovf_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_d       <= '0;
      r_pending     <= '0;
      r_ovf         <= '0;
      r_claim_valid <= 1'b0;
      r_claim_id    <= '0;
    end else begin
      r_src_d       <= src;
      r_pending     <= w_pending_next;
      r_ovf         <= w_ovf_next;
      r_claim_valid <= claim;
      if (claim) begin
        r_claim_id <= w_irq ? w_irq_id : NONE;
      end
    end
  end

  assign irq         = w_irq;
  assign irq_id      = w_irq_id;
  assign claim_valid = r_claim_valid;
  assign claim_id    = r_claim_id;
  assign pending     = r_pending;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl. It runs directed scenarios with literal expectations
// and then randomized traffic. A reference model tracks the sources as a set of
// pending events, and it is compared against the DUT on every falling edge.
module tb_irq_ctrl;

  localparam int N   = 8;
  localparam int IDW = 4;
  localparam logic [IDW-1:0] NONE = '1;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   src;
  logic [N-1:0]   mask;
  logic           claim;
  logic           ovf_clr;
  logic           irq;
  logic [IDW-1:0] irq_id;
  logic           claim_valid;
  logic [IDW-1:0] claim_id;
  logic [N-1:0]   pending;
  logic [N-1:0]   ovf;

  irq_ctrl #(.N(N), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src        (src),
    .mask       (mask),
    .claim      (claim),
    .ovf_clr    (ovf_clr),
    .irq        (irq),
    .irq_id     (irq_id),
    .claim_valid(claim_valid),
    .claim_id   (claim_id),
    .pending    (pending),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Reference model state.
  logic [N-1:0]   m_prev;
  logic [N-1:0]   m_pend;
  logic [N-1:0]   m_ovf;
  logic           m_cv;
  logic [IDW-1:0] m_cid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = '0;
    m_pend = '0;
    m_ovf  = '0;
    m_cv   = 1'b0;
    m_cid  = '0;
  endtask

  // Apply one clock edge's worth of rules to the model, using the current inputs.
  task automatic model_update();
    int c;
    c = -1;
    if (claim) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (m_pend[i] && mask[i]) c = i;
      end
      m_cv  = 1'b1;
      m_cid = (c < 0) ? NONE : c[IDW-1:0];
    end else begin
      m_cv = 1'b0;
    end
    if (ovf_clr) m_ovf = '0;
    for (int i = 0; i < N; i++) begin
      if (src[i] && !m_prev[i]) begin
        if (m_pend[i] && i != c) m_ovf[i] = 1'b1;
        m_pend[i] = 1'b1;
      end else if (i == c) begin
        m_pend[i] = 1'b0;
      end
    end
    m_prev = src;
  endtask

  // Compare process: DUT against model every cycle.
  always @(negedge clk) begin
    if (check_en) begin
      int e;
      e = -1;
      for (int i = N - 1; i >= 0; i--) begin
        if (m_pend[i] && mask[i]) e = i;
      end
      chk("cyc_pending",     32'(pending),     32'(m_pend));
      chk("cyc_ovf",         32'(ovf),         32'(m_ovf));
      chk("cyc_claim_valid", 32'(claim_valid), 32'(m_cv));
      chk("cyc_claim_id",    32'(claim_id),    32'(m_cid));
      chk("cyc_irq",         32'(irq),         32'(e >= 0));
      chk("cyc_irq_id",      32'(irq_id),      (e < 0) ? 32'(NONE) : 32'(e));
    end
  end

  // Drive inputs shortly after a rising edge, then let one edge go by. The
  // task returns 1 time unit after that edge, with the model updated.
  task automatic step(input logic [N-1:0] s, input logic [N-1:0] m,
                      input logic c, input logic oc);
    #1;
    src     = s;
    mask    = m;
    claim   = c;
    ovf_clr = oc;
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pending"},     32'(pending),     32'h0);
    chk({tag, "_ovf"},         32'(ovf),         32'h0);
    chk({tag, "_claim_valid"}, 32'(claim_valid), 32'h0);
    chk({tag, "_claim_id"},    32'(claim_id),    32'h0);
    chk({tag, "_irq"},         32'(irq),         32'h0);
    chk({tag, "_irq_id"},      32'(irq_id),      32'hF);
  endtask

  initial begin
    logic [N-1:0] rs;
    logic [N-1:0] rm;
    rst_n   = 1'b0;
    src     = '0;
    mask    = 8'hFF;
    claim   = 1'b0;
    ovf_clr = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("rst0");
    #2;
    rst_n    = 1'b1;
    check_en = 1'b1;

    // Single source: rise, claim.
    step(8'h08, 8'hFF, 1'b0, 1'b0);
    chk("s1_pending", 32'(pending), 32'h08);
    chk("s1_irq",     32'(irq),     32'h1);
    chk("s1_irq_id",  32'(irq_id),  32'h3);
    step(8'h08, 8'hFF, 1'b1, 1'b0);
    chk("s1_cv",      32'(claim_valid), 32'h1);
    chk("s1_cid",     32'(claim_id),    32'h3);
    chk("s1_pend0",   32'(pending),     32'h00);
    chk("s1_irq0",    32'(irq),         32'h0);
    step(8'h08, 8'hFF, 1'b0, 1'b0);
    chk("s1_cv_drop", 32'(claim_valid), 32'h0);
    chk("s1_cid_hold",32'(claim_id),    32'h3);

    // Two simultaneous sources and back-to-back claims.
    step(8'h2C, 8'hFF, 1'b0, 1'b0);
    chk("s2_irq_id",  32'(irq_id),   32'h2);
    step(8'h2C, 8'hFF, 1'b1, 1'b0);
    chk("s2_cid_a",   32'(claim_id), 32'h2);
    chk("s2_irq_id5", 32'(irq_id),   32'h5);
    step(8'h2C, 8'hFF, 1'b1, 1'b0);
    chk("s2_cid_b",   32'(claim_id), 32'h5);
    chk("s2_irq0",    32'(irq),      32'h0);
    step(8'h00, 8'hFF, 1'b0, 1'b0);

    // Claim with nothing pending.
    step(8'h00, 8'hFF, 1'b1, 1'b0);
    chk("s3_cv",      32'(claim_valid), 32'h1);
    chk("s3_cid",     32'(claim_id),    32'hF);
    chk("s3_pend",    32'(pending),     32'h00);

    // Overflow, overflow clear, and a rise that coincides with a claim.
    step(8'h02, 8'hFF, 1'b0, 1'b0);
    step(8'h00, 8'hFF, 1'b0, 1'b0);
    step(8'h02, 8'hFF, 1'b0, 1'b0);
    chk("s4_ovf",     32'(ovf),     32'h02);
    chk("s4_pend",    32'(pending), 32'h02);
    step(8'h00, 8'hFF, 1'b0, 1'b1);
    chk("s4_ovf_clr", 32'(ovf),     32'h00);
    step(8'h02, 8'hFF, 1'b1, 1'b0);
    chk("s4_setprio_pend", 32'(pending), 32'h02);
    chk("s4_setprio_ovf",  32'(ovf),     32'h00);
    chk("s4_setprio_cid",  32'(claim_id),32'h1);
    step(8'h00, 8'hFF, 1'b1, 1'b0);

    // A masked source stays pending and is reported as soon as it is unmasked.
    step(8'h10, 8'h00, 1'b0, 1'b0);
    chk("s5_pend",    32'(pending), 32'h10);
    chk("s5_irq0",    32'(irq),     32'h0);
    step(8'h10, 8'h00, 1'b1, 1'b0);
    chk("s5_masked_cid",  32'(claim_id), 32'hF);
    chk("s5_masked_pend", 32'(pending),  32'h10);
    #1;
    mask = 8'h10;
    #1;
    chk("s5_irq1",    32'(irq),    32'h1);
    chk("s5_irq_id",  32'(irq_id), 32'h4);
    step(8'h10, 8'h10, 1'b1, 1'b0);
    step(8'h00, 8'hFF, 1'b0, 1'b0);

    // Reset in the middle of operation.
    step(8'h0C, 8'hFF, 1'b0, 1'b0);
    step(8'h00, 8'hFF, 1'b0, 1'b0);
    step(8'h04, 8'hFF, 1'b0, 1'b0);
    chk("s6_pend",    32'(pending), 32'h0C);
    chk("s6_ovf",     32'(ovf),     32'h04);
    #1;
    src   = 8'h01;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("s6_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h01, 8'hFF, 1'b0, 1'b0);
    chk("s6_release_pend", 32'(pending), 32'h01);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      rs = src;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0) rs[i] = ~rs[i];
      end
      rm = ($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF;
      step(rs, rm, ($urandom_range(9) < 3), ($urandom_range(9) == 0));
    end

    step(8'h00, 8'hFF, 1'b0, 1'b0);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, the number of interrupt sources (legal range 2..15).
REQ-002 SHALL have parameter IDW, default 4, the width of the ID fields; N <= 2^IDW-1 is required.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port src  input  N  interrupt sources (for example timer irq), synchronous to clk, rising-edge sensitive.
REQ-006 SHALL have port mask  input  N  per-source enable (1 = enabled), sampled combinationally.
REQ-007 SHALL have port claim  input  1  single-cycle claim request from the CPU side.
REQ-008 SHALL have port ovf_clr  input  1  clears all overflow flags.
REQ-009 SHALL have port irq  output  1  interrupt request to the CPU.
REQ-010 SHALL have port irq_id  output  IDW  ID of the highest-priority eligible source.
REQ-011 SHALL have port claim_valid  output  1  one-cycle pulse acknowledging a claim.
REQ-012 SHALL have port claim_id  output  IDW  ID returned by the claim.
REQ-013 SHALL have port pending  output  N  pending register.
REQ-014 SHALL have port ovf  output  N  sticky per-source overflow flags.

Function
REQ-015 SHALL register src into src_d each cycle; rise[i] = src[i] & ~src_d[i].
REQ-016 SHALL set pending[i] at the clock edge where rise[i]=1.
REQ-017 SHALL define eligible = pending & mask, and drive irq = |eligible combinationally from the registered pending and the current mask.
REQ-018 SHALL drive irq_id combinationally as the lowest index i with eligible[i]=1 (index 0 = highest priority), or NONE = 2^IDW-1 when eligible is zero.
REQ-019 SHALL give a latency of one edge from src: a src rise sampled at edge t makes pending and irq visible in the cycle after edge t.
REQ-020 SHALL, on claim=1 with irq=1 at an edge, clear pending[irq_id] and register claim_id=irq_id and claim_valid=1.
REQ-021 SHALL, on claim=1 with irq=0, register claim_id=NONE and claim_valid=1, and change no pending bit.
REQ-022 SHALL hold claim_valid at 0 in every cycle not immediately following a claim edge; claim_id SHALL hold its last value.
REQ-023 SHALL give set priority when rise[i] coincides with a claim of i: pending[i] stays 1 and ovf[i] is not set.
REQ-024 SHALL set ovf[i] when rise[i]=1 while pending[i]=1 and i is not being claimed in that cycle.
REQ-025 SHALL keep ovf sticky; ovf_clr clears all bits, except that an ovf set event in the same cycle wins for its bit.
REQ-026 SHALL keep pending bits of masked sources set and report them once unmasked; a masked source is never claimed.
REQ-027 SHALL let back-to-back claims on consecutive cycles each claim the then-current irq_id.

Reset
REQ-028 SHALL, while rst_n=0, immediately clear src_d, pending, ovf, claim_valid (0) and claim_id (0); irq reads 0 and irq_id reads NONE.
REQ-029 SHALL, on reset release with src[i] held high, see a rise on the first active edge and set pending[i].
REQ-030 SHALL, on reset asserted mid-operation, lose all pending and claim state with no claim_valid pulse.

Verification
REQ-031 SHALL cover: N=8, mask=FF, src[3] 0->1 at edge t -> pending=08 and irq=1, irq_id=3 after edge t; claim -> claim_valid=1, claim_id=3, pending=00, irq=0.
REQ-032 SHALL cover: src[5] and src[2] rise in the same cycle -> irq_id=2; claim -> claim_id=2, irq_id=5; claim -> claim_id=5, irq=0.
REQ-033 SHALL cover: claim with pending=00 -> claim_valid=1, claim_id=F, pending unchanged.
REQ-034 SHALL cover: src[1] rises twice with no claim in between -> ovf=02 and pending=02; ovf_clr -> ovf=00; src[1] rise coinciding with claim of 1 -> pending[1]=1, ovf=00.
REQ-035 SHALL cover: mask=00 with src[4] rising -> pending=10, irq=0; mask=10 -> irq=1, irq_id=4 the same cycle.
REQ-036 SHALL cover: rst_n pulsed low with pending=0C and ovf=04 -> all outputs at reset values immediately; src[0] high at release -> pending=01 after the first edge.
